// File: rtl/apb_master_ctrl.sv
// APB requester: turns a valid/ready command into one APB SETUP/ACCESS transfer.
// It returns a single-cycle response that carries the read data, pslverr, a timeout flag or a bad-index error.
module apb_master_ctrl #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned SEL_WIDTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  localparam int unsigned SW            = $clog2(SEL_WIDTH),
  localparam int unsigned STRB_WIDTH    = DATA_WIDTH / 8
) (
  input  logic                  main_clk,
  input  logic                  main_rsn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_strb,
  input  logic [SW-1:0]         cmd_sel,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [SEL_WIDTH-1:0]  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [DATA_WIDTH-1:0] pwdata,
  output logic [STRB_WIDTH-1:0] pstrb,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [SW:0] SelLimit = (SW + 1)'(SEL_WIDTH);
  localparam logic [CW-1:0] CntLast =
      CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StErrRsp} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [SEL_WIDTH-1:0]  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [STRB_WIDTH-1:0] pstrb_q, pstrb_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;

  logic bad_sel;
  logic timeout_hit;

  assign bad_sel     = {1'b0, cmd_sel} >= SelLimit;
  // Expires on the ACCESS cycle that would make the wait count reach TIMEOUT_CYCLES.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CntLast);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    paddr_d       = paddr_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = '0;
    rsp_err_d     = 1'b0;
    rsp_timeout_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          cnt_d = '0;
          if (bad_sel) begin
            // No bus activity for a bad index: respond straight away.
            state_d     = StErrRsp;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d  = StSetup;
            paddr_d  = cmd_addr;
            pwrite_d = cmd_write;
            pwdata_d = cmd_wdata;
            pstrb_d  = cmd_write ? cmd_strb : '0;
            psel_d   = {{(SEL_WIDTH - 1){1'b0}}, 1'b1} << cmd_sel;
          end
        end
      end
      StSetup: begin
        state_d   = StAccess;
        penable_d = 1'b1;
      end
      StAccess: begin
        if (pready) begin
          state_d     = StIdle;
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = pslverr;
          rsp_rdata_d = (!pwrite_q && !pslverr) ? prdata : '0;
        end else if (timeout_hit) begin
          state_d       = StIdle;
          psel_d        = '0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StErrRsp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge main_clk or negedge main_rsn) begin
    if (!main_rsn) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      paddr_q       <= '0;
      psel_q        <= '0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      paddr_q       <= paddr_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready   = (state_q == StIdle) && main_rsn;
  assign paddr       = paddr_q;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign pwdata      = pwdata_q;
  assign pstrb       = pstrb_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule
